// File: rtl/mshr_pkg.sv
// Shared definitions for the MSHR bank: entry-state encoding, default widths
// and the lowest-index priority encoder used for free/wake selection.
package mshr_pkg;

  typedef enum logic [1:0] {
    ST_FREE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_WAKE    = 2'b10
  } entry_state_e;

  localparam int MAX_ENTRIES = 8;
  localparam int DEF_PA_W    = 15;
  localparam int DEF_OFF_W   = 4;
  localparam int LINE_W      = DEF_PA_W - DEF_OFF_W;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate with |vec).
  function automatic logic [2:0] lowest_set(input logic [MAX_ENTRIES-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mshr_entry.sv
// One MSHR entry: FREE/PENDING/WAKE state machine, line-tag register and the
// probe/fill tag comparators.
module mshr_entry
  import mshr_pkg::*;
#(
  parameter int TAG_W = LINE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [TAG_W-1:0] probe_tag,
  input  logic             fill_valid,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             release_wake,
  output logic             busy,
  output logic             probe_match,
  output logic             fill_match,
  output logic             is_wake,
  output logic [TAG_W-1:0] tag
);

  entry_state_e     state_reg;
  logic [TAG_W-1:0] tag_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_FREE;
      tag_reg   <= '0;
    end else begin
      case (state_reg)
        ST_FREE: begin
          if (alloc) begin
            state_reg <= ST_PENDING;
            tag_reg   <= alloc_tag;
          end
        end
        ST_PENDING: if (fill_match) state_reg <= ST_WAKE;
        ST_WAKE:    if (release_wake) state_reg <= ST_FREE;
        default:    state_reg <= ST_FREE;
      endcase
    end
  end

  assign busy        = (state_reg != ST_FREE);
  assign is_wake     = (state_reg == ST_WAKE);
  // Probe covers WAKE entries too so a line cannot be re-missed before its wake retires.
  assign probe_match = busy && (tag_reg == probe_tag);
  assign fill_match  = fill_valid && (state_reg == ST_PENDING) && (tag_reg == fill_tag);
  assign tag         = tag_reg;

endmodule

// File: rtl/mshr_bank.sv
// MSHR file for one cache bank: allocation, merge detection, fill tracking and
// a held wake handshake. Defining MSHR_STATS_EN builds saturating alloc/merge counters.
module mshr_bank
  import mshr_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int PA_W    = DEF_PA_W,
  parameter int OFF_W   = DEF_OFF_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MSHR_valid,
  input  logic [PA_W-1:0] MSHR_pAddress,
  output logic            MSHR_HIT,
  output logic            MSHR_FULL,
  input  logic            fill_valid,
  input  logic [PA_W-1:0] fill_pAddress,
  output logic            wake_valid,
  output logic [PA_W-1:0] wake_pAddress,
  input  logic            wake_ready,
  output logic [3:0]      occupancy,
  output logic            fill_err,
  output logic [15:0]     stat_alloc,
  output logic [15:0]     stat_merge
);

  localparam int TAG_W = PA_W - OFF_W;

  logic [ENTRIES-1:0]     busy, probe_match, fill_match, is_wake;
  logic [ENTRIES-1:0]     alloc_sel, release_sel, busy_next;
  logic [TAG_W-1:0]       entry_tag [ENTRIES];
  logic [TAG_W-1:0]       probe_tag, fill_tag, wake_tag_next;
  logic [MAX_ENTRIES-1:0] free_vec, wake_cand;
  logic [2:0]             alloc_idx, wake_idx_next, wake_idx_reg;
  logic                   alloc_go;
  logic                   wake_valid_reg, full_reg, fill_err_reg;
  logic [PA_W-1:0]        wake_addr_reg;
  logic [3:0]             occ_next, occ_reg;
  logic                   unused_offset_bits;

  assign probe_tag          = MSHR_pAddress[PA_W-1:OFF_W];
  assign fill_tag           = fill_pAddress[PA_W-1:OFF_W];
  assign unused_offset_bits = ^{MSHR_pAddress[OFF_W-1:0], fill_pAddress[OFF_W-1:0]};

  assign MSHR_HIT  = |probe_match;
  assign alloc_go  = MSHR_valid & ~MSHR_HIT & ~full_reg;
  assign free_vec  = MAX_ENTRIES'(~busy);
  assign alloc_idx = lowest_set(free_vec);
  assign busy_next = (busy & ~release_sel) | alloc_sel;

  // Wake candidates as they will stand after this edge: accepted entry gone, new fills in.
  assign wake_cand     = MAX_ENTRIES'((is_wake & ~release_sel) | fill_match);
  assign wake_idx_next = lowest_set(wake_cand);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign alloc_sel[gi]   = alloc_go && (alloc_idx == 3'(gi));
      assign release_sel[gi] = wake_valid_reg && wake_ready && (wake_idx_reg == 3'(gi));

      mshr_entry #(.TAG_W(TAG_W)) u_entry (
        .clk          (clk),
        .rst          (rst),
        .alloc        (alloc_sel[gi]),
        .alloc_tag    (probe_tag),
        .probe_tag    (probe_tag),
        .fill_valid   (fill_valid),
        .fill_tag     (fill_tag),
        .release_wake (release_sel[gi]),
        .busy         (busy[gi]),
        .probe_match  (probe_match[gi]),
        .fill_match   (fill_match[gi]),
        .is_wake      (is_wake[gi]),
        .tag          (entry_tag[gi])
      );
    end
  endgenerate

  always_comb begin
    wake_tag_next = '0;
    occ_next      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (wake_idx_next == 3'(i)) wake_tag_next = entry_tag[i];
      occ_next = occ_next + 4'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg       <= 1'b0;
      occ_reg        <= '0;
      fill_err_reg   <= 1'b0;
      wake_valid_reg <= 1'b0;
      wake_idx_reg   <= '0;
      wake_addr_reg  <= '0;
    end else begin
      full_reg <= &busy_next;
      occ_reg  <= occ_next;
      if (fill_valid && !(|fill_match)) fill_err_reg <= 1'b1;
      // The presented wake is held until accepted, even if a lower entry fills meanwhile.
      if (!wake_valid_reg || wake_ready) begin
        wake_valid_reg <= |wake_cand;
        wake_idx_reg   <= wake_idx_next;
        wake_addr_reg  <= (|wake_cand) ? {wake_tag_next, {OFF_W{1'b0}}} : '0;
      end
    end
  end

  assign MSHR_FULL     = full_reg;
  assign occupancy     = occ_reg;
  assign fill_err      = fill_err_reg;
  assign wake_valid    = wake_valid_reg;
  assign wake_pAddress = wake_addr_reg;

`ifdef MSHR_STATS_EN
  logic        merge_go;
  logic [15:0] stat_alloc_reg, stat_merge_reg;

  assign merge_go = MSHR_valid & MSHR_HIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_alloc_reg <= '0;
      stat_merge_reg <= '0;
    end else begin
      if (alloc_go && stat_alloc_reg != 16'hFFFF) stat_alloc_reg <= stat_alloc_reg + 16'd1;
      if (merge_go && stat_merge_reg != 16'hFFFF) stat_merge_reg <= stat_merge_reg + 16'd1;
    end
  end

  assign stat_alloc = stat_alloc_reg;
  assign stat_merge = stat_merge_reg;
`else
  assign stat_alloc = '0;
  assign stat_merge = '0;
`endif

endmodule

// File: tb/tb_mshr_bank.sv
// Self-checking bench for mshr_bank: directed scenarios plus randomized traffic
// compared against a line-level reference model of the MSHR file.
module tb_mshr_bank;

  localparam int ENTRIES = 4;
  localparam int PA_W    = 15;
  localparam int OFF_W   = 4;
`ifdef MSHR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            MSHR_valid = 1'b0;
  logic [PA_W-1:0] MSHR_pAddress = '0;
  logic            MSHR_HIT, MSHR_FULL;
  logic            fill_valid = 1'b0;
  logic [PA_W-1:0] fill_pAddress = '0;
  logic            wake_valid;
  logic [PA_W-1:0] wake_pAddress;
  logic            wake_ready = 1'b0;
  logic [3:0]      occupancy;
  logic            fill_err;
  logic [15:0]     stat_alloc, stat_merge;

  always #5 clk = ~clk;

  mshr_bank #(.ENTRIES(ENTRIES), .PA_W(PA_W), .OFF_W(OFF_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .MSHR_valid    (MSHR_valid),
    .MSHR_pAddress (MSHR_pAddress),
    .MSHR_HIT      (MSHR_HIT),
    .MSHR_FULL     (MSHR_FULL),
    .fill_valid    (fill_valid),
    .fill_pAddress (fill_pAddress),
    .wake_valid    (wake_valid),
    .wake_pAddress (wake_pAddress),
    .wake_ready    (wake_ready),
    .occupancy     (occupancy),
    .fill_err      (fill_err),
    .stat_alloc    (stat_alloc),
    .stat_merge    (stat_merge)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: per-slot line number, outstanding flag and filled flag.
  bit m_busy   [ENTRIES];
  bit m_waking [ENTRIES];
  int m_line   [ENTRIES];
  bit m_wv;
  int m_widx;
  int m_waddr;
  bit m_err;
  int m_alloc, m_merge;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit m_hit(input int addr);
    for (int i = 0; i < ENTRIES; i++)
      if (m_busy[i] && m_line[i] == (addr >> OFF_W)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_busy[i] = 1'b0; m_waking[i] = 1'b0; m_line[i] = 0;
    end
    m_wv = 1'b0; m_widx = 0; m_waddr = 0; m_err = 1'b0; m_alloc = 0; m_merge = 0;
  endtask

  task automatic compare_model();
    check("hit", MSHR_HIT, m_hit(int'(MSHR_pAddress)));
    check("full", MSHR_FULL, m_occ() == ENTRIES);
    check("occupancy", occupancy, m_occ());
    check("wake_valid", wake_valid, m_wv);
    if (m_wv) check("wake_addr", wake_pAddress, m_waddr);
    check("fill_err", fill_err, m_err);
    check("stat_alloc", stat_alloc, STATS ? m_alloc : 0);
    check("stat_merge", stat_merge, STATS ? m_merge : 0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_occupancy"}, occupancy, 0);
    check({pfx, "_full"}, MSHR_FULL, 0);
    check({pfx, "_hit"}, MSHR_HIT, 0);
    check({pfx, "_wake_valid"}, wake_valid, 0);
    check({pfx, "_wake_addr"}, wake_pAddress, 0);
    check({pfx, "_fill_err"}, fill_err, 0);
    check({pfx, "_stat_alloc"}, stat_alloc, 0);
    check({pfx, "_stat_merge"}, stat_merge, 0);
  endtask

  // One clock cycle: drive, compare against the model, advance the model by the edge.
  task automatic step(input bit v, input int addr, input bit fv, input int faddr, input bit wr);
    bit hit, full;
    int fm, rel, ai;
    string ev;
    MSHR_valid    = v;
    MSHR_pAddress = PA_W'(addr);
    fill_valid    = fv;
    fill_pAddress = PA_W'(faddr);
    wake_ready    = wr;
    #1;
    compare_model();
    hit  = m_hit(addr);
    full = (m_occ() == ENTRIES);
    fm = -1;
    if (fv)
      for (int i = 0; i < ENTRIES; i++)
        if (m_busy[i] && !m_waking[i] && m_line[i] == (faddr >> OFF_W)) fm = i;
    rel = (m_wv && wr) ? m_widx : -1;
    ai = -1;
    if (v && !hit && !full)
      for (int i = ENTRIES - 1; i >= 0; i--) if (!m_busy[i]) ai = i;
    ev = "";
    if (v && hit) begin
      if (m_merge < 'hFFFF) m_merge++;
      ev = {ev, $sformatf(" merge 0x%h", addr)};
    end
    if (v && !hit && full) ev = {ev, $sformatf(" drop 0x%h", addr)};
    if (ai >= 0) begin
      m_busy[ai] = 1'b1; m_waking[ai] = 1'b0; m_line[ai] = addr >> OFF_W;
      if (m_alloc < 'hFFFF) m_alloc++;
      ev = {ev, $sformatf(" alloc 0x%h->e%0d", addr, ai)};
    end
    if (fv && fm < 0) begin
      m_err = 1'b1;
      ev = {ev, $sformatf(" stray-fill 0x%h", faddr)};
    end
    if (fm >= 0) begin
      m_waking[fm] = 1'b1;
      ev = {ev, $sformatf(" fill 0x%h->e%0d", faddr, fm)};
    end
    if (rel >= 0) begin
      m_busy[rel] = 1'b0; m_waking[rel] = 1'b0;
      ev = {ev, $sformatf(" wake-accept 0x%h", m_waddr)};
    end
    if (!m_wv || wr) begin
      m_wv = 1'b0; m_waddr = 0;
      for (int i = ENTRIES - 1; i >= 0; i--)
        if (m_waking[i]) begin
          m_wv = 1'b1; m_widx = i; m_waddr = m_line[i] << OFF_W;
        end
    end
    if (ev != "") $display("cycle %0d:%s", cyc, ev);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic probe(input int addr, input bit exp_hit);
    MSHR_valid = 1'b0; fill_valid = 1'b0; wake_ready = 1'b0;
    MSHR_pAddress = PA_W'(addr);
    #1;
    check($sformatf("probe_0x%h", addr), MSHR_HIT, exp_hit);
  endtask

  // Asynchronous reset raised and dropped mid-cycle.
  task automatic mid_reset();
    MSHR_valid = 1'b0; fill_valid = 1'b0; wake_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    $display("cycle %0d: async reset", cyc);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int line, addr, faddr, pick;
    bit fv;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    step(1, 'h1230, 0, 0, 0);
    check("occ_first_alloc", occupancy, 1);
    probe('h1238, 1'b1);
    probe('h1240, 1'b0);
    step(1, 'h1240, 0, 0, 0);
    step(1, 'h1250, 0, 0, 0);
    step(1, 'h1260, 0, 0, 0);
    check("full_four", MSHR_FULL, 1);
    check("occ_four", occupancy, 4);
    step(1, 'h1270, 0, 0, 0);
    check("occ_after_drop", occupancy, 4);
    probe('h1270, 1'b0);

    step(0, 0, 1, 'h1234, 0);
    check("wake_after_fill", wake_valid, 1);
    check("wake_addr_after_fill", wake_pAddress, 'h1230);
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      check("wake_hold_valid", wake_valid, 1);
      check("wake_hold_addr", wake_pAddress, 'h1230);
    end
    step(0, 0, 0, 0, 1);
    check("occ_after_accept", occupancy, 3);
    check("full_after_accept", MSHR_FULL, 0);
    check("wake_after_accept", wake_valid, 0);

    step(1, 'h1248, 1, 'h1244, 0);
    check("occ_fill_merge", occupancy, 3);
    probe('h1240, 1'b1);
    check("wake_addr_merge", wake_pAddress, 'h1240);
    step(0, 0, 0, 0, 0);
    probe('h1240, 1'b1);
    step(0, 0, 0, 0, 1);
    probe('h1240, 1'b0);
    check("occ_after_merge_wake", occupancy, 2);
    step(1, 'h1258, 0, 0, 0);
    check("occ_pending_merge", occupancy, 2);
    check("stat_alloc_directed", stat_alloc, STATS ? 4 : 0);
    check("stat_merge_directed", stat_merge, STATS ? 2 : 0);

    step(0, 0, 1, 'h7FF0, 0);
    check("fill_err_set", fill_err, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("fill_err_sticky", fill_err, 1);
    mid_reset();

    for (int n = 0; n < 400; n++) begin
      if (n == 200) mid_reset();
      line = 'h120 + int'($urandom_range(0, 7));
      addr = (line << OFF_W) | int'($urandom_range(0, 15));
      fv = ($urandom_range(0, 2) == 0);
      pick = int'($urandom_range(0, ENTRIES - 1));
      if (m_busy[pick] && !m_waking[pick] && $urandom_range(0, 7) != 0)
        faddr = (m_line[pick] << OFF_W) | int'($urandom_range(0, 15));
      else
        faddr = (('h120 + int'($urandom_range(0, 7))) << OFF_W) | int'($urandom_range(0, 15));
      step($urandom_range(0, 1) == 1, addr, fv, faddr, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
